cld_clk_gate_ctrl: RTL and testbench

//   Auto clock-gating controller. Produces en_o for the en_i input of cld_clk_gate.

---
 rtl/cld_clk_gate_pkg.sv | 20 ++
 rtl/cld_sat_cnt.sv | 26 ++
 rtl/cld_clk_gate_ctrl.sv | 116 +++++++++++
 tb/tb_cld_clk_gate_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cld_clk_gate_pkg.sv
// Shared types and width helpers for the auto clock-gating controller.
package cld_clk_gate_pkg;

   // Controller states: clock running, clock gated, clock waking up.
   typedef enum logic [1:0] {
      ST_ON   = 2'd0,
      ST_OFF  = 2'd1,
      ST_WAKE = 2'd2
   } cg_state_t;

   localparam int unsigned IDLE_CYCLES_DEF = 32'd16;
   localparam int unsigned WAKE_CYCLES_DEF = 32'd2;
   localparam int unsigned STAT_W_DEF      = 32'd16;

   // Width of a counter that must hold values 0..n.
   function automatic int unsigned cnt_w(input int unsigned n);
      return $clog2(n + 32'd1);
   endfunction

endpackage

// File: rtl/cld_sat_cnt.sv
// Saturating event counter: counts inc_i pulses, sticks at all-ones.
module cld_sat_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] r_cnt;

   // Synchronous clear has priority; increment only below all-ones.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         r_cnt <= {W{1'b0}};
      end else if (inc_i && (r_cnt != {W{1'b1}})) begin
         r_cnt <= r_cnt + W'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign cnt_o = r_cnt;

endmodule

// File: rtl/cld_clk_gate_ctrl.sv
// Auto clock-gating controller. Gates the clock after IDLE_CYCLES idle
// cycles, wakes it on any activity and holds requests off for WAKE_CYCLES.
module cld_clk_gate_ctrl
   import cld_clk_gate_pkg::*;
#(
   parameter int unsigned IDLE_CYCLES = IDLE_CYCLES_DEF,
   parameter int unsigned WAKE_CYCLES = WAKE_CYCLES_DEF,
   parameter int unsigned STAT_W      = STAT_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              dft_mode_test_mode_i,
   input  logic              sw_force_on_i,
   input  logic              sw_gate_en_i,
   input  logic              busy_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   output logic              en_o,
   output logic              gated_o,
   output logic [STAT_W-1:0] stat_gate_cnt_o
);

   localparam int unsigned IDLE_W = cnt_w(IDLE_CYCLES);
   localparam int unsigned WAKE_W = cnt_w(WAKE_CYCLES);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 32'd1);
   localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 32'd1);

   cg_state_t         r_state;
   cg_state_t         w_state_nxt;
   logic [IDLE_W-1:0] r_idle_cnt;
   logic [IDLE_W-1:0] w_idle_cnt_nxt;
   logic [WAKE_W-1:0] r_wake_cnt;
   logic [WAKE_W-1:0] w_wake_cnt_nxt;
   logic              r_en;
   logic              r_ready;
   logic              r_gated;
   logic              w_idle;
   logic              w_gate_evt;

   assign w_idle = sw_gate_en_i & ~sw_force_on_i & ~dft_mode_test_mode_i
                 & ~busy_i & ~req_valid_i;

   // Next-state and counter logic; activity always wins over the idle threshold.
   always_comb begin
      w_state_nxt    = r_state;
      w_idle_cnt_nxt = {IDLE_W{1'b0}};
      w_wake_cnt_nxt = {WAKE_W{1'b0}};
      w_gate_evt     = 1'b0;
      case (r_state)
         ST_ON: begin
            if (w_idle) begin
               if (r_idle_cnt == IDLE_LAST) begin
                  w_state_nxt = ST_OFF;
                  w_gate_evt  = 1'b1;
               end else begin
                  w_idle_cnt_nxt = r_idle_cnt + IDLE_W'(1);
               end
            end else begin
               w_idle_cnt_nxt = {IDLE_W{1'b0}};
            end
         end
         ST_OFF: begin
            if (!w_idle) begin
               w_state_nxt = ST_WAKE;
            end else begin
               w_state_nxt = ST_OFF;
            end
         end
         ST_WAKE: begin
            // Once started, the wake sequence always runs to completion.
            if (r_wake_cnt == WAKE_LAST) begin
               w_state_nxt = ST_ON;
            end else begin
               w_wake_cnt_nxt = r_wake_cnt + WAKE_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_ON;
         end
      endcase
   end

   // State, counters and registered outputs decoded from the next state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_ON;
         r_idle_cnt <= {IDLE_W{1'b0}};
         r_wake_cnt <= {WAKE_W{1'b0}};
         r_en       <= 1'b1;
         r_ready    <= 1'b1;
         r_gated    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_idle_cnt <= w_idle_cnt_nxt;
         r_wake_cnt <= w_wake_cnt_nxt;
         r_en       <= (w_state_nxt != ST_OFF);
         r_ready    <= (w_state_nxt == ST_ON);
         r_gated    <= (w_state_nxt == ST_OFF);
      end
   end

   cld_sat_cnt #(
      .W (STAT_W)
   ) u_stat_cnt (
      .clk_i (clk_i),
      .clr_i (rst_i),
      .inc_i (w_gate_evt),
      .cnt_o (stat_gate_cnt_o)
   );

   // Test mode bypasses the register so the clock runs in the same cycle.
   assign en_o        = r_en | dft_mode_test_mode_i;
   assign req_ready_o = r_ready;
   assign gated_o     = r_gated;

endmodule

// File: tb/tb_cld_clk_gate_ctrl.sv
// Directed self-checking bench for cld_clk_gate_ctrl with a scoreboard queue.
module tb_cld_clk_gate_ctrl;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        dft = 1'b0;
   logic        force_on = 1'b0;
   logic        gate_en = 1'b1;
   logic        busy = 1'b0;
   logic        req_valid = 1'b0;

   logic        ready, en, gated;
   logic [15:0] stat;
   logic        ready2, en2, gated2;
   logic [1:0]  stat2;

   int errors = 0;
   int checks = 0;
   int xfers  = 0;

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;
   exp_t sb_q[$];

   cld_clk_gate_ctrl #(.IDLE_CYCLES(16), .WAKE_CYCLES(2), .STAT_W(16)) dut (
      .clk_i(clk), .rst_i(rst_i), .dft_mode_test_mode_i(dft),
      .sw_force_on_i(force_on), .sw_gate_en_i(gate_en), .busy_i(busy),
      .req_valid_i(req_valid), .req_ready_o(ready), .en_o(en),
      .gated_o(gated), .stat_gate_cnt_o(stat)
   );

   cld_clk_gate_ctrl #(.IDLE_CYCLES(16), .WAKE_CYCLES(2), .STAT_W(2)) dut_sat (
      .clk_i(clk), .rst_i(rst_i), .dft_mode_test_mode_i(dft),
      .sw_force_on_i(force_on), .sw_gate_en_i(gate_en), .busy_i(busy),
      .req_valid_i(req_valid), .req_ready_o(ready2), .en_o(en2),
      .gated_o(gated2), .stat_gate_cnt_o(stat2)
   );

   always #5 clk = ~clk;

   // One clock edge; tally handshakes seen going into the edge, then settle.
   task automatic step();
      if (req_valid && ready) xfers++;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [15:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic pop_chk(input logic [15:0] obs);
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   // Push expectation and compare immediately against the current output.
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] v);
      push(tag, v);
      pop_chk(obs);
   endtask

   initial begin
      logic saw_low;
      // Reset state
      step(); step();
      chk("rst_en", {15'd0, en}, 16'd1);
      chk("rst_ready", {15'd0, ready}, 16'd1);
      chk("rst_gated", {15'd0, gated}, 16'd0);
      chk("rst_stat", stat, 16'd0);

      // Busy pulse every 10 cycles: never gate
      rst_i = 1'b0;
      saw_low = 1'b0;
      for (int i = 0; i < 60; i++) begin
         busy = ((i % 10) == 0);
         step();
         if (!en) saw_low = 1'b1;
      end
      busy = 1'b0;
      chk("busy_en_never_low", {15'd0, saw_low}, 16'd0);
      chk("busy_stat", stat, 16'd0);

      // Idle gating after exactly 16 idle edges
      rst_i = 1'b1; step(); rst_i = 1'b0;
      repeat (15) step();
      chk("idle15_en", {15'd0, en}, 16'd1);
      chk("idle15_gated", {15'd0, gated}, 16'd0);
      step();
      chk("idle16_en", {15'd0, en}, 16'd0);
      chk("idle16_gated", {15'd0, gated}, 16'd1);
      chk("idle16_ready", {15'd0, ready}, 16'd0);
      chk("idle16_stat", stat, 16'd1);

      // Wake on request, ready after 1 + WAKE_CYCLES cycles
      xfers = 0;
      req_valid = 1'b1;
      push("wake_c0_ready", 16'd0);
      pop_chk({15'd0, ready});
      push("wake_c1_en", 16'd1);
      push("wake_c1_ready", 16'd0);
      push("wake_c1_gated", 16'd0);
      step();
      pop_chk({15'd0, en}); pop_chk({15'd0, ready}); pop_chk({15'd0, gated});
      push("wake_c2_ready", 16'd0);
      step();
      pop_chk({15'd0, ready});
      push("wake_c3_ready", 16'd1);
      step();
      pop_chk({15'd0, ready});
      step();
      req_valid = 1'b0;
      step(); step();
      chk("wake_xfers", xfers[15:0], 16'd1);

      // Activity on the 16th idle cycle cancels gating and clears the count
      gate_en = 1'b0; step(); gate_en = 1'b1;
      repeat (15) step();
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      chk("thr_act_en", {15'd0, en}, 16'd1);
      chk("thr_act_gated", {15'd0, gated}, 16'd0);
      repeat (15) step();
      chk("thr_recount15_en", {15'd0, en}, 16'd1);
      step();
      chk("thr_recount16_en", {15'd0, en}, 16'd0);
      chk("thr_stat", stat, 16'd2);

      // DFT mode in OFF: en immediately, then WAKE and ON
      dft = 1'b1;
      #1;
      chk("dft_en_comb", {15'd0, en}, 16'd1);
      chk("dft_gated_still", {15'd0, gated}, 16'd1);
      step();
      chk("dft_wake_gated", {15'd0, gated}, 16'd0);
      chk("dft_wake_ready", {15'd0, ready}, 16'd0);
      step();
      chk("dft_wake2_ready", {15'd0, ready}, 16'd0);
      step();
      chk("dft_on_ready", {15'd0, ready}, 16'd1);
      dft = 1'b0;

      // Reset during WAKE
      repeat (16) step();
      chk("pre_rst_en", {15'd0, en}, 16'd0);
      chk("pre_rst_stat", stat, 16'd3);
      req_valid = 1'b1;
      step();
      chk("in_wake_ready", {15'd0, ready}, 16'd0);
      rst_i = 1'b1;
      step();
      chk("rst_wake_en", {15'd0, en}, 16'd1);
      chk("rst_wake_ready", {15'd0, ready}, 16'd1);
      chk("rst_wake_gated", {15'd0, gated}, 16'd0);
      chk("rst_wake_stat", stat, 16'd0);
      rst_i = 1'b0;
      req_valid = 1'b0;

      // Saturation of a 2-bit statistics counter over 5 gate events
      for (int k = 1; k <= 5; k++) begin
         repeat (16) step();
         chk("sat_gated", {15'd0, gated}, 16'd1);
         chk("sat_stat16", stat, 16'(k));
         chk("sat_stat2", {14'd0, stat2}, (k > 3) ? 16'd3 : 16'(k));
         req_valid = 1'b1;
         repeat (3) step();
         req_valid = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
